// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared defaults, meter state encoding and helpers for the
//               DDS I/Q period meter.
// Revision    : 1.0  initial release
// ============================================================================
package dds_pkg;

    localparam int c_dw_def = 19;
    localparam int c_cw_def = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } meter_state_t;

    // A request for zero crossings still needs one to define a period.
    function automatic logic [7:0] ncyc_eff(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_iq_zcd.sv
`default_nettype none
// ============================================================================
// Module      : dds_iq_zcd
// Description : Splits the interleaved X/Y stream into pairs and flags
//               negative-to-positive zero crossings of X, one check per pair.
// Revision    : 1.0  initial release
// ============================================================================
module dds_iq_zcd
    import dds_pkg::*;
#(
    parameter int DW = c_dw_def
) (
    input  logic          dclk,
    input  logic          rst,
    input  logic          iq,
    input  logic [DW-1:0] doxy,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic          xyv,
    output logic          xing
);

    logic [DW-1:0] r_hold;
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y;
    logic          r_xyv;
    logic          r_xing;

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_hold <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_xyv  <= 1'b0;
            r_xing <= 1'b0;
        end else begin
            r_xyv  <= ~iq;
            r_xing <= 1'b0;
            if (iq) begin
                r_hold <= doxy;
            end else begin
                // Crossing compares the outgoing x against the one being loaded.
                r_x    <= r_hold;
                r_y    <= doxy;
                r_xing <= r_x[DW-1] & ~r_hold[DW-1];
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign xyv  = r_xyv;
    assign xing = r_xing;

endmodule
`default_nettype wire

// File: rtl/dds_iq_meter.sv
`default_nettype none
// ============================================================================
// Module      : dds_iq_meter
// Description : Deinterleaves DDS X/Y samples and measures the period, in
//               pairs, over a requested number of X zero crossings.
//               Define DDS_IQ_METER_PEAK_EN to enable peak |X| tracking.
// Revision    : 1.0  initial release
// ============================================================================
module dds_iq_meter
    import dds_pkg::*;
#(
    parameter int DW = c_dw_def,
    parameter int CW = c_cw_def
) (
    input  logic          dclk,
    input  logic          rst,
    input  logic          iq,
    input  logic [DW-1:0] doxy,
    input  logic          start,
    input  logic [7:0]    ncyc,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic          xyv,
    output logic [CW-1:0] per,
    output logic          perv,
    output logic          ovf,
    output logic          busy,
    output logic [DW-2:0] pk
);

    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    meter_state_t  r_state;
    meter_state_t  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [7:0]    r_rem;
    logic [7:0]    w_rem_nxt;
    logic          r_ovf;
    logic          w_ovf_nxt;
    logic          w_fin;
    logic          w_xing;
    logic [CW-1:0] r_per;
    logic          r_perv;

    dds_iq_zcd #(
        .DW   (DW)
    ) u_zcd (
        .dclk (dclk),
        .rst  (rst),
        .iq   (iq),
        .doxy (doxy),
        .x    (x),
        .y    (y),
        .xyv  (xyv),
        .xing (w_xing)
    );

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_ovf   <= 1'b0;
            r_per   <= '0;
            r_perv  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_ovf   <= w_ovf_nxt;
            r_perv  <= w_fin;
            if (w_fin) begin
                r_per <= w_cnt_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_ovf_nxt   = r_ovf;
        w_fin       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = '0;
                    w_rem_nxt   = ncyc_eff(ncyc);
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_ARM: begin
                if (xyv) begin
                    if (w_xing) begin
                        w_state_nxt = ST_COUNT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_cnt_max - c_cnt_one) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = c_cnt_max;
                        w_ovf_nxt   = 1'b1;
                        w_fin       = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_cnt_one;
                    end
                end
            end
            ST_COUNT: begin
                if (xyv) begin
                    // Saturation wins over a crossing that lands on the same pair.
                    if (r_cnt == c_cnt_max - c_cnt_one) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = c_cnt_max;
                        w_ovf_nxt   = 1'b1;
                        w_fin       = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                        if (w_xing) begin
                            w_rem_nxt = r_rem - 8'd1;
                            if (r_rem == 8'd1) begin
                                w_state_nxt = ST_DONE;
                                w_fin       = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign per  = r_per;
    assign perv = r_perv;
    assign ovf  = r_ovf;
    assign busy = (r_state != ST_IDLE);

`ifdef DDS_IQ_METER_PEAK_EN
    logic [DW-1:0] w_neg;
    logic [DW-2:0] w_abs;
    logic [DW-2:0] r_pk;

    // The most negative sample has no positive twin, so it clips to full scale.
    always_comb begin
        w_neg = ~x + DW'(1);
        if (!x[DW-1]) begin
            w_abs = x[DW-2:0];
        end else if (w_neg[DW-1]) begin
            w_abs = '1;
        end else begin
            w_abs = w_neg[DW-2:0];
        end
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            r_pk <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_pk <= '0;
        end else if (xyv && (w_abs > r_pk)) begin
            r_pk <= w_abs;
        end
    end

    assign pk = r_pk;
`else
    assign pk = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dds_iq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_iq_meter
// Description : Randomized self-checking bench for dds_iq_meter against a
//               pair-index period model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dds_iq_meter;
    import dds_pkg::*;

    localparam int DW = 19;
    localparam int CW = 10;
    localparam int c_max = (1 << CW) - 1;
    localparam logic [DW-1:0] c_xmin = {1'b1, {(DW-1){1'b0}}};

    logic          dclk = 1'b0;
    logic          rst;
    logic          iq;
    logic [DW-1:0] doxy;
    logic          start;
    logic [7:0]    ncyc;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          xyv;
    logic [CW-1:0] per;
    logic          perv;
    logic          ovf;
    logic          busy;
    logic [DW-2:0] pk;

    dds_iq_meter #(
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .dclk  (dclk),
        .rst   (rst),
        .iq    (iq),
        .doxy  (doxy),
        .start (start),
        .ncyc  (ncyc),
        .x     (x),
        .y     (y),
        .xyv   (xyv),
        .per   (per),
        .perv  (perv),
        .ovf   (ovf),
        .busy  (busy),
        .pk    (pk)
    );

    always #5 dclk = ~dclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    int            perv_cnt = 0;
    logic [CW-1:0] last_per;
    logic          last_ovf;
    logic [DW-1:0] last_x = '0;

    always @(negedge dclk) begin
        if (perv) begin
            perv_cnt++;
            last_per = per;
            last_ovf = ovf;
        end
    end

    task automatic cyc(input logic q, input logic [DW-1:0] d, input logic s);
        @(negedge dclk);
        iq    = q;
        doxy  = d;
        start = s;
        @(posedge dclk);
    endtask

    task automatic drive_pair(input logic [DW-1:0] xv, input logic s);
        cyc(1'b1, xv, s);
        cyc(1'b0, DW'($urandom), 1'b0);
        last_x = xv;
    endtask

    function automatic int absx(input logic [DW-1:0] v);
        int s;
        s = int'($signed(v));
        if (s >= 0) return s;
        if (v == c_xmin) return (1 << (DW-1)) - 1;
        return -s;
    endfunction

    // Negative for the first half of each P-pair period; P=0 gives all positive.
    function automatic logic [DW-1:0] gen(input int ph, input int p);
        logic [DW-1:0] v;
        if (p > 0 && (ph % p) < p / 2) begin
            if ($urandom_range(0, 15) == 0) v = c_xmin;
            else v = DW'(-int'($urandom_range(1, (1 << (DW-1)) - 1)));
        end else begin
            v = DW'($urandom_range(0, (1 << (DW-1)) - 1));
        end
        return v;
    endfunction

    task automatic measure(input int p, input logic [7:0] nc, input bit poke, input int len);
        logic [DW-1:0] xs[$];
        logic [DW-1:0] prev;
        int k1, kend, ncr, need, ph, nd, p0, exp_per, pkm;
        bit exp_ovf;
        need = (nc == 0) ? 1 : int'(nc);
        ph   = $urandom_range(0, 63);
        for (int k = 0; k < len; k++) xs.push_back(gen(k + ph, p));
        prev = last_x; k1 = -1; kend = -1; ncr = 0;
        for (int k = 0; k < len; k++) begin
            if (prev[DW-1] && !xs[k][DW-1]) begin
                if (k1 < 0) k1 = k;
                else begin
                    ncr++;
                    if (ncr == need && kend < 0) kend = k;
                end
            end
            prev = xs[k];
        end
        if (k1 < 0 || k1 >= c_max || kend < 0 || kend - k1 >= c_max) begin
            exp_per = c_max; exp_ovf = 1'b1;
        end else begin
            exp_per = kend - k1; exp_ovf = 1'b0;
        end

        ncyc = nc;
        p0   = perv_cnt;
        cyc(1'b1, '0, 1'b1);
        #1 check("busy_after_start", busy, 1);
        cyc(1'b1, '0, 1'b0);
        nd = 0; pkm = 0;
        while (nd < len && perv_cnt == p0) begin
            drive_pair(xs[nd], poke && k1 >= 0 && nd == k1 + 2);
            if (absx(xs[nd]) > pkm) pkm = absx(xs[nd]);
            nd++;
        end
        check("perv_timeout", (perv_cnt == p0) ? 1 : 0, 0);
        repeat (4) cyc(1'b1, '0, 1'b0);
        #1;
        check("perv_pulses", perv_cnt - p0, 1);
        check("per", last_per, exp_per);
        check("ovf", last_ovf, exp_ovf);
        check("busy_idle", busy, 0);
`ifdef DDS_IQ_METER_PEAK_EN
        check("pk", pk, pkm);
`else
        check("pk_tied", pk, 0);
`endif
    endtask

    initial begin
        int pr;
        logic [7:0] nr;
        rst = 1'b1; iq = 1'b1; doxy = '0; start = 1'b1; ncyc = 8'd1;
        repeat (3) @(posedge dclk);
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_xyv", xyv, 0);
        check("rst_per", per, 0);
        check("rst_perv", perv, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_pk", pk, 0);
        @(negedge dclk); rst = 1'b0; start = 1'b0;

        // Deinterleave a single directed pair.
        cyc(1'b1, DW'('h00123), 1'b0);
        cyc(1'b0, DW'('h7FF00), 1'b0);
        last_x = DW'('h00123);
        #1;
        check("di_x", x, 'h00123);
        check("di_y", y, 'h7FF00);
        check("di_xyv_hi", xyv, 1);
        cyc(1'b1, '0, 1'b0);
        #1 check("di_xyv_lo", xyv, 0);

        // Peak of the most negative sample, then cleared by start.
        drive_pair(c_xmin, 1'b0);
        cyc(1'b1, '0, 1'b0);
        #1;
`ifdef DDS_IQ_METER_PEAK_EN
        check("pk_min", pk, 'h3FFFF);
`else
        check("pk_min_tied", pk, 0);
`endif
        cyc(1'b1, '0, 1'b1);
        #1 check("pk_start_clr", pk, 0);
        @(negedge dclk); rst = 1'b1; start = 1'b0;
        @(posedge dclk);
        @(negedge dclk); rst = 1'b0;
        last_x = '0;

        for (int r = 0; r < 8; r++) begin
            pr = $urandom_range(6, 40);
            nr = 8'($urandom_range(0, 4));
            measure(pr, nr, r[0], ((nr == 0 ? 1 : int'(nr)) + 2) * pr + 8);
        end
        measure(0, 8'd3, 1'b0, c_max + 80);

        // Reset in COUNT aborts without a result.
        begin
            int p0;
            ncyc = 8'd5;
            p0   = perv_cnt;
            cyc(1'b1, '0, 1'b1);
            for (int k = 0; k < 30; k++) drive_pair(gen(k, 8), 1'b0);
            #1 check("abort_busy_before", busy, 1);
            @(negedge dclk); rst = 1'b1;
            @(posedge dclk);
            @(negedge dclk); rst = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_x", x, 0);
            check("abort_per", per, 0);
            last_x = '0;
            for (int k = 0; k < 40; k++) drive_pair(gen(k, 8), 1'b0);
            repeat (3) cyc(1'b1, '0, 1'b0);
            check("abort_no_perv", perv_cnt - p0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_iq_meter.md
DDS_IQ_METER -- requirements
Module: dds_iq_meter

Interface
REQ-001 SHALL have parameter DW, default 19, meaning sample width of doxy, x and y.
REQ-002 SHALL have parameter CW, default 24, meaning width of the period counter.
REQ-003 SHALL have port dclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iq, input, 1 bit: phase of the multiplexed stream; 1 means doxy carries X, 0 means doxy carries Y.
REQ-006 SHALL have port doxy, input, DW bits: signed two's-complement interleaved X/Y samples from the DDS.
REQ-007 SHALL have port start, input, 1 bit: one-clock request to begin a period measurement.
REQ-008 SHALL have port ncyc, input, 8 bits: number of X zero crossings to measure over; 0 is treated as 1.
REQ-009 SHALL have ports x and y, output, DW bits each: the deinterleaved sample pair.
REQ-010 SHALL have port xyv, output, 1 bit: one-clock strobe marking a new x/y pair.
REQ-011 SHALL have port per, output, CW bits: measured pair count.
REQ-012 SHALL have port perv, output, 1 bit: one-clock strobe marking a new per value.
REQ-013 SHALL have port ovf, output, 1 bit: set when the last measurement saturated.
REQ-014 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-015 SHALL have port pk, output, DW-1 bits: peak |X|.

Function
REQ-016 SHALL capture doxy into an X holding register on every edge with iq=1.
REQ-017 SHALL, on every edge with iq=0, load x from the X holding register and y from doxy, and assert xyv on the following cycle only.
REQ-018 SHALL, if iq is high on two consecutive edges, use the most recent X.
REQ-019 SHALL, if iq is low on two consecutive edges, form a pair on each edge.
REQ-020 SHALL count a zero crossing when the sign bit of consecutive x values goes from 1 to 0, evaluated once per pair.
REQ-021 SHALL implement a state machine with states IDLE, ARM, COUNT and DONE.
REQ-022 SHALL move IDLE to ARM on start, clearing the count, loading the remaining-crossings register with max(ncyc,1), clearing ovf and clearing pk.
REQ-023 SHALL move ARM to COUNT on the first crossing, with the count set to 0.
REQ-024 SHALL, in COUNT, increment the count by 1 per pair and decrement the remaining-crossings register on each crossing.
REQ-025 SHALL move COUNT to DONE when the remaining-crossings register reaches 0.
REQ-026 SHALL, if the count reaches 2^CW-1 in ARM or COUNT, hold the count at that value, set ovf=1 and move to DONE.
REQ-027 SHALL, in DONE, load per with the count, assert perv for one cycle and return to IDLE on the next edge.
REQ-028 SHALL ignore start in any state other than IDLE.
REQ-029 SHALL, when start and a crossing occur on the same cycle in IDLE, honour start and not count that crossing.
REQ-030 SHALL drive busy = (state != IDLE).

Reset
REQ-031 SHALL, on rst, force state IDLE and set x, y, xyv, per, perv, ovf, pk, the count and the holding register to 0, overriding start in the same cycle.
REQ-032 SHALL, on rst asserted mid-measurement, abort the measurement with no perv.

Configuration
REQ-033 SHALL, with DDS_IQ_METER_PEAK_EN defined, update pk per pair as max(pk, |x|), with |−2^(DW-1)| saturated to 2^(DW-1)-1.
REQ-034 SHALL, without DDS_IQ_METER_PEAK_EN defined, tie pk to 0 and include no peak logic.

Structure
REQ-035 SHALL place the DW and CW defaults and the state enumeration in a shared package dds_pkg.
REQ-036 SHALL place pair formation and crossing detection in a sub-module dds_iq_zcd, with the state machine and counters in dds_iq_meter.

Verification
REQ-037 Deinterleave: doxy=0x00123 with iq=1, then doxy=0x7FF00 with iq=0 -> x=0x00123, y=0x7FF00, xyv high for exactly one cycle.
REQ-038 Single-crossing period: dds2k19 feeding the block with frq=0x00040000, ncyc=1, start -> per=16384, perv for one pulse, ovf=0.
REQ-039 Multi-crossing period: same source with ncyc=4 -> per=65536; ncyc=0 -> per=16384.
REQ-040 Saturation: frq=0, start -> count saturates, per=0xFFFFFF, ovf=1, busy falls after the perv pulse.
REQ-041 Reset and start-while-busy: rst in COUNT -> busy=0 next cycle, no perv; start pulsed during COUNT -> result unchanged from a run without it.
REQ-042 Peak (macro defined): single pair with X=-262144 -> pk=0x3FFFF; next start -> pk=0.
